// File: rtl/wb_regfile_writer.sv
// ============================================================================
// Module   : wb_regfile_writer
// Purpose  : Write-back stage. Selects the write-back value, commits it to the
//            32-entry register file, serves two read ports and counts writes.
// Option   : WB_BYPASS_EN - read ports forward the in-flight write-back value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_regfile_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        flagsWB,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] direction,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [ADDR_W-1:0] last_rd,
    output logic [DATA_W-1:0] last_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_regs [NREGS];
    logic [ADDR_W-1:0] r_last_rd;
    logic [DATA_W-1:0] r_last_data;
    logic [CNT_W-1:0]  r_wr_count;

    assign wb_data = flagsWB[0] ? mem_data : direction;
    assign wb_we   = flagsWB[1] && (rd != '0);

    // r0 is hardwired to zero; it has no storage at all.
    assign w_regs[0] = '0;

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_reg
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (wb_we && (rd == ADDR_W'(i))) begin
                    r_q <= wb_data;
                end
            end

            assign w_regs[i] = r_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_rd   <= '0;
            r_last_data <= '0;
            r_wr_count  <= '0;
        end else if (wb_we) begin
            r_last_rd   <= rd;
            r_last_data <= wb_data;
            if (r_wr_count != '1) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    assign last_rd   = r_last_rd;
    assign last_data = r_last_data;
    assign wr_count  = r_wr_count;

    always_comb begin
        rs_data = w_regs[rs_addr];
        rt_data = w_regs[rt_addr];
`ifdef WB_BYPASS_EN
        // Forwarding is suppressed in reset so the ports read zero throughout.
        if (!rst && wb_we && (rs_addr == rd)) begin
            rs_data = wb_data;
        end
        if (!rst && wb_we && (rt_addr == rd)) begin
            rt_data = wb_data;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile_writer.sv
// ============================================================================
// Module   : tb_wb_regfile_writer
// Purpose  : Directed self-checking bench for wb_regfile_writer (CNT_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        flagsWB;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] direction;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic [ADDR_W-1:0] last_rd;
    logic [DATA_W-1:0] last_data;
    logic [CNT_W-1:0]  wr_count;

    int n_checks;
    int n_fail;

    wb_regfile_writer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flagsWB  (flagsWB),
        .mem_data (mem_data),
        .direction(direction),
        .rd       (rd),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wb_data  (wb_data),
        .wb_we    (wb_we),
        .last_rd  (last_rd),
        .last_data(last_data),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one MEM/WB entry on the falling edge, as the pipeline register does.
    task automatic drive(input logic [1:0] f, input logic [31:0] md, input logic [31:0] dir,
                         input logic [4:0] d);
        @(negedge clk);
        flagsWB   = f;
        mem_data  = md;
        direction = dir;
        rd        = d;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        flagsWB   = 2'b00;
        mem_data  = '0;
        direction = '0;
        rd        = '0;
        rs_addr   = 5'd7;
        rt_addr   = 5'd3;

        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(wr_count), 32'd0);
        check("reset_last_rd", 32'(last_rd), 32'd0);
        check("reset_last_data", last_data, 32'd0);
        check("reset_rs", rs_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU write to r7
        drive(2'b10, 32'h0, 32'hDEADBEEF, 5'd7);
        #1;
        check("alu_wb_we", 32'(wb_we), 32'd1);
        check("alu_wb_data", wb_data, 32'hDEADBEEF);
        check("alu_pre_commit_rs", rs_data, `ifdef WB_BYPASS_EN 32'hDEADBEEF `else 32'h0 `endif);
        commit();
        check("alu_rs7", rs_data, 32'hDEADBEEF);
        check("alu_count", 32'(wr_count), 32'd1);
        check("alu_last_rd", 32'(last_rd), 32'd7);
        check("alu_last_data", last_data, 32'hDEADBEEF);

        // Load write to r3
        drive(2'b11, 32'h0000CAFE, 32'h100, 5'd3);
        #1;
        check("load_wb_data", wb_data, 32'h0000CAFE);
        commit();
        check("load_rt3", rt_data, 32'h0000CAFE);
        check("load_count", 32'(wr_count), 32'd2);
        check("load_last_rd", 32'(last_rd), 32'd3);

        // Write to r0 is discarded
        drive(2'b11, 32'hFFFFFFFF, 32'h0, 5'd0);
        rs_addr = 5'd0;
        #1;
        check("r0_wb_we", 32'(wb_we), 32'd0);
        check("r0_wb_data", wb_data, 32'hFFFFFFFF);
        commit();
        check("r0_read", rs_data, 32'd0);
        check("r0_count", 32'(wr_count), 32'd2);
        check("r0_last_rd", 32'(last_rd), 32'd3);
        check("r0_last_data", last_data, 32'h0000CAFE);

        // Same-cycle write/read of r9 on both ports
        drive(2'b10, 32'h0, 32'h55, 5'd9);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        #1;
        check("byp_rs_pre", rs_data, `ifdef WB_BYPASS_EN 32'h55 `else 32'h0 `endif);
        check("byp_rt_pre", rt_data, `ifdef WB_BYPASS_EN 32'h55 `else 32'h0 `endif);
        commit();
        check("byp_rs_post", rs_data, 32'h55);
        check("byp_rt_post", rt_data, 32'h55);
        check("byp_count", 32'(wr_count), 32'd3);

        // Bubble with stale rd/data must not change anything
        drive(2'b00, 32'h1111, 32'h2222, 5'd7);
        rs_addr = 5'd7;
        #1;
        check("bubble_wb_we", 32'(wb_we), 32'd0);
        commit();
        check("bubble_rs7", rs_data, 32'hDEADBEEF);
        check("bubble_count", 32'(wr_count), 32'd3);
        check("bubble_last_rd", 32'(last_rd), 32'd9);
        check("bubble_last_data", last_data, 32'h55);

        // 20 more writes: counter must stop at 15
        for (int i = 0; i < 20; i++) begin
            drive(2'b10, 32'h0, 32'h1000 + 32'(i), 5'(i % 31 + 1));
            commit();
            if (i == 11) check("sat_reach", 32'(wr_count), 32'd15);
        end
        check("sat_hold", 32'(wr_count), 32'd15);
        check("sat_last_rd", 32'(last_rd), 32'd20);
        check("sat_last_data", last_data, 32'h1013);
        drive(2'b00, 32'h0, 32'h0, 5'd20);
        commit();
        check("sat_bubble", 32'(wr_count), 32'd15);

        // Write r5, then assert reset mid-cycle
        drive(2'b10, 32'h0, 32'h1234, 5'd5);
        rs_addr = 5'd5;
        rt_addr = 5'd7;
        commit();
        check("pre_rst_r5", rs_data, 32'h1234);
        drive(2'b10, 32'h0, 32'h9999, 5'd5);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_r5", rs_data, 32'd0);
        check("rst_async_r7", rt_data, 32'd0);
        check("rst_async_count", 32'(wr_count), 32'd0);
        check("rst_async_last_rd", 32'(last_rd), 32'd0);
        check("rst_async_last_data", last_data, 32'd0);
        commit();
        check("rst_edge_r5", rs_data, 32'd0);
        check("rst_edge_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        flagsWB = 2'b00;
        commit();
        check("post_rst_r5", rs_data, 32'd0);
        check("post_rst_count", 32'(wr_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
